// File: rtl/secp256k1_point_decompress_if.sv
// ---------------------------------------------------------------------------
// secp256k1_point_decompress_if
//
// Request/response bundle for the secp256k1 point decompressor.
//
//   start        requester -> core   request pulse, sampled only when idle
//   x_in         requester -> core   compressed x coordinate (256 bits)
//   y_parity     requester -> core   required LSB of y (0 = prefix 02, 1 = 03)
//   busy         core -> requester   operation in flight
//   done         core -> requester   one-cycle pulse, result valid
//   valid_point  core -> requester   x lies on the curve and y_out is usable
//   y_out        core -> requester   recovered y coordinate (256 bits)
//
// The requester side uses the master modport; the core uses slave.
// ---------------------------------------------------------------------------
interface secp256k1_point_decompress_if;
    logic         start;
    logic [255:0] x_in;
    logic         y_parity;
    logic         busy;
    logic         done;
    logic         valid_point;
    logic [255:0] y_out;

    modport master (
        output start, x_in, y_parity,
        input  busy, done, valid_point, y_out
    );

    modport slave (
        input  start, x_in, y_parity,
        output busy, done, valid_point, y_out
    );
endinterface

// File: rtl/secp256k1_point_decompress.sv
// ---------------------------------------------------------------------------
// secp256k1_point_decompress
//
// Expands a compressed secp256k1 public key (x plus y parity) into its
// affine y coordinate:  y = (x^3 + 7)^((p+1)/4) mod p, followed by a
// squaring check and a parity-driven choice between r and p - r.
//
// All arithmetic runs on one MSB-first interleaved modular multiplier
// (1 load cycle + 256 iteration cycles per product).  The exponentiation
// always performs both the square and the multiply for every exponent bit,
// so the latency for any in-range x is fixed and data independent.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; aborts any operation in flight
//   bus    secp256k1_point_decompress_if.slave
//            start / x_in / y_parity in; busy / done / valid_point / y_out out
// ---------------------------------------------------------------------------
module secp256k1_point_decompress (
    input  logic                               clk,
    input  logic                               reset,
    secp256k1_point_decompress_if.slave        bus
);

    // Field prime and the square-root exponent (p+1)/4; p = 3 mod 4, so
    // a^((p+1)/4) is a square root of a whenever a is a quadratic residue.
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] E_SQRT =
        256'h3FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_BFFFFF0C;
    localparam logic [257:0] P_ACC = {2'b00, P};
    localparam logic [256:0] P_ADD = {1'b0, P};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL_LOAD,
        MUL_ITER,
        ADD7,
        RESOLVE,
        FINISH
    } state_t;

    // Which product the shared multiplier is working on; selects operands
    // and the destination register.
    typedef enum logic [2:0] {
        PH_SQR_X,
        PH_CUBE,
        PH_EXP_SQR,
        PH_EXP_MUL,
        PH_VERIFY
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;

    // x_q holds x until the cube is formed and is then reused to hold the
    // verification square s, since x is no longer needed by that point.
    logic [255:0]  x_q;
    logic          parity_q;
    // t_q holds x^2, then x^3, then a = x^3 + 7 for the rest of the run.
    logic [255:0]  t_q;
    logic [255:0]  r_q;
    logic [257:0]  acc_q;
    logic [7:0]    bit_q;
    logic [7:0]    exp_q;
    logic [255:0]  y_q;
    logic          valid_q;

    logic [255:0]  mul_a;
    logic [255:0]  mul_b;
    logic [257:0]  acc_dbl;
    logic [257:0]  acc_dbl_red;
    logic [257:0]  acc_sum;
    logic [257:0]  acc_sum_red;
    logic [257:0]  acc_next;
    logic [256:0]  t_plus7;
    logic [255:0]  add7_res;
    logic          on_curve;
    logic [255:0]  y_sel;
    logic          valid_sel;

    // Operand selection for the shared multiplier.  Sources are not written
    // until the final iteration, so they can feed the datapath directly
    // without a separate operand latch (S2 reads and writes t_q safely).
    always_comb begin
        mul_a = r_q;
        mul_b = r_q;
        case (phase_q)
            PH_SQR_X: begin
                mul_a = x_q;
                mul_b = x_q;
            end
            PH_CUBE: begin
                mul_a = t_q;
                mul_b = x_q;
            end
            PH_EXP_MUL: begin
                mul_a = r_q;
                mul_b = t_q;
            end
            default: begin
                mul_a = r_q;
                mul_b = r_q;
            end
        endcase
    end

    // One interleaved multiplier iteration: double then conditionally add,
    // each followed by a single conditional subtraction.  With acc < p both
    // intermediate values stay below 2p, so one subtraction always suffices.
    always_comb begin
        acc_dbl     = acc_q << 1;
        acc_dbl_red = (acc_dbl >= P_ACC) ? (acc_dbl - P_ACC) : acc_dbl;
        acc_sum     = acc_dbl_red + {2'b00, mul_a};
        acc_sum_red = (acc_sum >= P_ACC) ? (acc_sum - P_ACC) : acc_sum;
        acc_next    = mul_b[bit_q] ? acc_sum_red : acc_dbl_red;
    end

    // a = x^3 + 7 reduced mod p.
    always_comb begin
        t_plus7  = {1'b0, t_q} + 257'd7;
        add7_res = (t_plus7 >= P_ADD) ? 256'(t_plus7 - P_ADD) : t_plus7[255:0];
    end

    // Final decision.  r == 0 can only be reached with an odd parity request
    // (0 is even), and zero has no odd counterpart, so that case is invalid.
    always_comb begin
        on_curve  = (x_q == t_q);
        y_sel     = '0;
        valid_sel = 1'b0;
        if (on_curve) begin
            if (r_q[0] == parity_q) begin
                y_sel     = r_q;
                valid_sel = 1'b1;
            end else if (r_q != '0) begin
                y_sel     = P - r_q;
                valid_sel = 1'b1;
            end
        end
    end

    // Next-state logic.  The exponent loop alternates square and multiply
    // phases for 256 bits, then runs one verification square.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (x_q >= P) begin
                    state_d = FINISH;
                end else begin
                    state_d = MUL_LOAD;
                    phase_d = PH_SQR_X;
                end
            end
            MUL_LOAD: begin
                state_d = MUL_ITER;
            end
            MUL_ITER: begin
                if (bit_q == 8'd0) begin
                    case (phase_q)
                        PH_SQR_X: begin
                            state_d = MUL_LOAD;
                            phase_d = PH_CUBE;
                        end
                        PH_CUBE: begin
                            state_d = ADD7;
                        end
                        PH_EXP_SQR: begin
                            state_d = MUL_LOAD;
                            phase_d = PH_EXP_MUL;
                        end
                        PH_EXP_MUL: begin
                            state_d = MUL_LOAD;
                            phase_d = (exp_q == 8'd0) ? PH_VERIFY : PH_EXP_SQR;
                        end
                        PH_VERIFY: begin
                            state_d = RESOLVE;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
            ADD7: begin
                state_d = MUL_LOAD;
                phase_d = PH_EXP_SQR;
            end
            RESOLVE: begin
                state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.  Products are written to their
    // destination on the last iteration; the exponent-multiply result is
    // only kept when the exponent bit is set, but the product is always
    // computed so timing never depends on E.  RESOLVE registers y/valid one
    // cycle ahead of FINISH so the outputs are stable when done is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= PH_SQR_X;
            x_q      <= '0;
            parity_q <= 1'b0;
            t_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            bit_q    <= 8'd0;
            exp_q    <= 8'd0;
            y_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q      <= bus.x_in;
                        parity_q <= bus.y_parity;
                        y_q      <= '0;
                        valid_q  <= 1'b0;
                    end
                end
                MUL_LOAD: begin
                    acc_q <= '0;
                    bit_q <= 8'd255;
                end
                MUL_ITER: begin
                    acc_q <= acc_next;
                    bit_q <= bit_q - 8'd1;
                    if (bit_q == 8'd0) begin
                        case (phase_q)
                            PH_SQR_X, PH_CUBE: begin
                                t_q <= acc_next[255:0];
                            end
                            PH_EXP_SQR: begin
                                r_q <= acc_next[255:0];
                            end
                            PH_EXP_MUL: begin
                                if (E_SQRT[exp_q]) begin
                                    r_q <= acc_next[255:0];
                                end
                                exp_q <= exp_q - 8'd1;
                            end
                            PH_VERIFY: begin
                                x_q <= acc_next[255:0];
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ADD7: begin
                    t_q   <= add7_res;
                    r_q   <= 256'd1;
                    exp_q <= 8'd255;
                end
                RESOLVE: begin
                    y_q     <= y_sel;
                    valid_q <= valid_sel;
                end
                default: begin
                end
            endcase
        end
    end

    // busy covers every working state but drops as done pulses.
    assign bus.busy        = (state_q != IDLE) && (state_q != FINISH);
    assign bus.done        = (state_q == FINISH);
    assign bus.y_out       = y_q;
    assign bus.valid_point = valid_q;

endmodule

// File: tb/tb_secp256k1_point_decompress.sv
// ---------------------------------------------------------------------------
// tb_secp256k1_point_decompress
//
// Self-checking bench for secp256k1_point_decompress.  Requests are queued
// on a scoreboard when accepted; a monitor pops and compares each result
// (valid flag, y, latency) when done pulses.
// ---------------------------------------------------------------------------
module tb_secp256k1_point_decompress;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY_EVEN =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] GY_ODD =
        256'hB7C52588_D95C3B9A_A25B0403_F1EEF757_02E84BB7_597AABE6_63B82F6F_04EF2777;
    localparam logic [255:0] ALL_ONES = {256{1'b1}};
    localparam int LAT_FULL  = 132359;
    localparam int LAT_RANGE = 2;

    typedef struct {
        string        name;
        logic [255:0] x;
        logic         parity;
        logic         exp_valid;
        logic [255:0] exp_y;
        int           exp_lat;
    } vec_t;

    typedef struct {
        string        name;
        logic         exp_valid;
        logic [255:0] exp_y;
        int           exp_lat;
        int           accept_cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[3];

    secp256k1_point_decompress_if bus ();

    secp256k1_point_decompress dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurement.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drives a request at a point away from the clock edge and waits for the
    // accepting edge.  When track is set the expected result is queued.
    task automatic applyStimulus(input logic [255:0] x, input logic parity,
                                 input bit track, input logic exp_valid,
                                 input logic [255:0] exp_y, input int exp_lat,
                                 input string name);
        exp_t e;
        bus.start    = 1'b1;
        bus.x_in     = x;
        bus.y_parity = parity;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (track) begin
            e.name         = name;
            e.exp_valid    = exp_valid;
            e.exp_y        = exp_y;
            e.exp_lat      = exp_lat;
            e.accept_cycle = cycle - 1;
            sb_q.push_back(e);
        end
        checkOutput({name, "_busy_after_accept"}, 256'(bus.busy), 256'd1);
        checkOutput({name, "_y_cleared"}, bus.y_out, '0);
        checkOutput({name, "_valid_cleared"}, 256'(bus.valid_point), 256'd0);
    endtask

    // Waits (bounded) for done; returns at the falling edge inside the done cycle.
    task automatic waitDone(input int limit, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got no done within %0d cycles, expected done", name, limit);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest request.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput({mon_e.name, "_valid"}, 256'(bus.valid_point), 256'(mon_e.exp_valid));
                checkOutput({mon_e.name, "_y"}, bus.y_out, mon_e.exp_y);
                checkOutput({mon_e.name, "_latency"}, 256'(cycle - mon_e.accept_cycle),
                            256'(mon_e.exp_lat));
                checkOutput({mon_e.name, "_busy_at_done"}, 256'(bus.busy), 256'd0);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.x_in     = '0;
        bus.y_parity = 1'b0;

        vecs[0] = '{"x_eq_p",    P,        1'b0, 1'b0, 256'd0, LAT_RANGE};
        vecs[1] = '{"x_all_ones", ALL_ONES, 1'b1, 1'b0, 256'd0, LAT_RANGE};
        vecs[2] = '{"x_zero",    256'd0,   1'b0, 1'b0, 256'd0, LAT_FULL};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 256'(bus.busy), 256'd0);
        checkOutput("reset_done", 256'(bus.done), 256'd0);
        checkOutput("reset_valid", 256'(bus.valid_point), 256'd0);
        checkOutput("reset_y", bus.y_out, '0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven: out-of-range and off-curve requests.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].x, vecs[i].parity, 1'b1, vecs[i].exp_valid,
                          vecs[i].exp_y, vecs[i].exp_lat, vecs[i].name);
            waitDone(vecs[i].exp_lat + 16, vecs[i].name);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_held_valid"}, 256'(bus.valid_point),
                        256'(vecs[i].exp_valid));
            checkOutput({vecs[i].name, "_held_y"}, bus.y_out, vecs[i].exp_y);
            checkOutput({vecs[i].name, "_idle_busy"}, 256'(bus.busy), 256'd0);
        end

        // Reset 1000 cycles into a generator request: aborts with no done.
        applyStimulus(GX, 1'b0, 1'b0, 1'b1, GY_EVEN, LAT_FULL, "abort_gen");
        repeat (1000) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 256'(bus.busy), 256'd0);
        checkOutput("abort_done", 256'(bus.done), 256'd0);
        checkOutput("abort_y", bus.y_out, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("abort_still_idle", 256'(bus.busy), 256'd0);

        // Generator, even parity, with a stray start while busy.
        @(negedge clk);
        applyStimulus(GX, 1'b0, 1'b1, 1'b1, GY_EVEN, LAT_FULL, "gen_even");
        repeat (500) @(negedge clk);
        bus.start    = 1'b1;
        bus.x_in     = 256'd0;
        bus.y_parity = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(LAT_FULL + 16, "gen_even");

        // Back-to-back: start raised during the done cycle is ignored and
        // accepted on the following cycle; first result held until then.
        bus.start    = 1'b1;
        bus.x_in     = GX;
        bus.y_parity = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_done_cycle_start_ignored", 256'(bus.busy), 256'd0);
        checkOutput("b2b_first_y_held", bus.y_out, GY_EVEN);
        checkOutput("b2b_first_valid_held", 256'(bus.valid_point), 256'd1);
        applyStimulus(GX, 1'b1, 1'b1, 1'b1, GY_ODD, LAT_FULL, "gen_odd");
        waitDone(LAT_FULL + 16, "gen_odd");
        repeat (4) @(negedge clk);

        checkOutput("scoreboard_empty", 256'(sb_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
